// File: rtl/segment_sequencer.sv
// -----------------------------------------------------------------------------
// segment_sequencer
//
// N-segment double-buffered settings bank plus sample index sequencer. The host
// writes per-segment CYCLE / FREQ_DIV / REP entries into the bank at any time.
// The running segment works from its own active copy of those settings. That
// copy is reloaded only when the sequencer switches segment, so bank writes
// never disturb the waveform currently being played.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   wr_en        write bank entry wr_segment with wr_cycle/wr_freq_div/wr_rep
//   wr_segment   bank entry to write (out-of-range values are ignored)
//   wr_cycle     last index of the segment (entries - 1)
//   wr_freq_div  clocks per index step (0 behaves as 1)
//   wr_rep       loop count - 1; all-ones means repeat forever
//   update       pulse: request a switch to req_segment
//   req_segment  target segment (out-of-range values are ignored)
//   req_mode     0 immediate, 1 at wrap, 2 at sync, 3 behaves as immediate
//   sync         one-cycle pulse from the sync timer
//   idx          current sample index (BRAM read address)
//   segment      active segment
//   stop         finite repeat exhausted, idx held at the last index
//   pending      a switch request is waiting for its trigger
// -----------------------------------------------------------------------------
module segment_sequencer #(
    parameter int NUM_SEGMENTS   = 2,
    parameter int CYCLE_WIDTH    = 16,
    parameter int FREQ_DIV_WIDTH = 32,
    parameter int REP_WIDTH      = 32,
    localparam int SEG_W         = $clog2(NUM_SEGMENTS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [SEG_W-1:0]          wr_segment,
    input  logic [CYCLE_WIDTH-1:0]    wr_cycle,
    input  logic [FREQ_DIV_WIDTH-1:0] wr_freq_div,
    input  logic [REP_WIDTH-1:0]      wr_rep,
    input  logic                      update,
    input  logic [SEG_W-1:0]          req_segment,
    input  logic [1:0]                req_mode,
    input  logic                      sync,
    output logic [CYCLE_WIDTH-1:0]    idx,
    output logic [SEG_W-1:0]          segment,
    output logic                      stop,
    output logic                      pending
);

    localparam logic [1:0] MODE_IMMEDIATE = 2'd0;
    localparam logic [1:0] MODE_AT_WRAP   = 2'd1;
    localparam logic [1:0] MODE_AT_SYNC   = 2'd2;

    typedef enum logic {ST_RUN, ST_WAIT} state_t;

    // Settings bank
    logic [CYCLE_WIDTH-1:0]    bank_cycle [NUM_SEGMENTS];
    logic [FREQ_DIV_WIDTH-1:0] bank_div   [NUM_SEGMENTS];
    logic [REP_WIDTH-1:0]      bank_rep   [NUM_SEGMENTS];

    // FSM state and the request it is holding
    state_t     state_q, state_d;
    logic [SEG_W-1:0] pend_seg_q, pend_seg_d;
    logic [1:0] pend_mode_q, pend_mode_d;

    // Sequencer datapath
    logic [CYCLE_WIDTH-1:0]    idx_q, idx_d;
    logic [SEG_W-1:0]          seg_q, seg_d;
    logic                      stop_q, stop_d;
    logic [FREQ_DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [REP_WIDTH-1:0]      loop_cnt_q, loop_cnt_d;
    logic [CYCLE_WIDTH-1:0]    act_cycle_q, act_cycle_d;
    logic [FREQ_DIV_WIDTH-1:0] act_div_q, act_div_d;
    logic [REP_WIDTH-1:0]      act_rep_q, act_rep_d;

    // Decoded events
    logic                      wr_ok, upd_ok;
    logic [1:0]                mode_eff;
    logic [FREQ_DIV_WIDTH-1:0] div_last;
    logic                      tick, at_end, wrap, finish;
    logic                      new_imm, new_wait, pend_trig, do_switch;
    logic [SEG_W-1:0]          switch_seg;
    logic                      bypass;

    assign wr_ok    = wr_en  && (int'(wr_segment)  < NUM_SEGMENTS);
    assign upd_ok   = update && (int'(req_segment) < NUM_SEGMENTS);
    assign mode_eff = (req_mode == 2'd3) ? MODE_IMMEDIATE : req_mode;

    // A divider of 0 behaves as 1: terminal count is 0 in both cases.
    assign div_last = (act_div_q == '0) ? '0 : act_div_q - 1'b1;
    assign tick     = !stop_q && (div_cnt_q == div_last);
    assign at_end   = (idx_q == act_cycle_q);
    assign wrap     = tick && at_end;
    // loop_cnt is compared before it increments, so no saturation is needed.
    assign finish   = wrap && !(&act_rep_q) && (loop_cnt_q == act_rep_q);

    // An AT_WRAP request on a stopped segment would never see a wrap, so it
    // is promoted to an immediate switch.
    assign new_imm  = upd_ok && ((mode_eff == MODE_IMMEDIATE) ||
                                 (mode_eff == MODE_AT_WRAP && stop_q));
    assign new_wait = upd_ok && !new_imm;

    // Only a request already held in WAIT can fire; a request arriving in the
    // same cycle as sync or wrap waits for the next one.
    assign pend_trig = (state_q == ST_WAIT) &&
                       (((pend_mode_q == MODE_AT_WRAP) && (wrap || stop_q)) ||
                        ((pend_mode_q == MODE_AT_SYNC) && sync));

    assign do_switch  = new_imm || pend_trig;
    assign switch_seg = new_imm ? req_segment : pend_seg_q;
    assign bypass     = wr_ok && (wr_segment == switch_seg);

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    // NOTE: sequential blocks use non-blocking (<=) so every register samples
    // the pre-edge values; combinational blocks use blocking (=).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pend_seg_q  <= '0;
            pend_mode_q <= MODE_IMMEDIATE;
        end else begin
            state_q     <= state_d;
            pend_seg_q  <= pend_seg_d;
            pend_mode_q <= pend_mode_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        pend_seg_d  = pend_seg_q;
        pend_mode_d = pend_mode_q;
        if (new_imm) begin
            state_d = ST_RUN;                 // overrides any held request
        end else if (new_wait) begin
            state_d     = ST_WAIT;            // replaces the held request
            pend_seg_d  = req_segment;
            pend_mode_d = mode_eff;
        end else if (pend_trig) begin
            state_d = ST_RUN;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        idx     = idx_q;
        segment = seg_q;
        stop    = stop_q;
        pending = (state_q == ST_WAIT);
    end

    // ---------------------------------------------------------------------
    // Sequencer datapath
    // ---------------------------------------------------------------------
    always_comb begin
        idx_d       = idx_q;
        seg_d       = seg_q;
        stop_d      = stop_q;
        div_cnt_d   = div_cnt_q;
        loop_cnt_d  = loop_cnt_q;
        act_cycle_d = act_cycle_q;
        act_div_d   = act_div_q;
        act_rep_d   = act_rep_q;

        if (do_switch) begin
            seg_d      = switch_seg;
            idx_d      = '0;
            stop_d     = 1'b0;
            div_cnt_d  = '0;
            loop_cnt_d = '0;
            // A write landing on the target in the switch cycle is taken
            // directly, since the bank itself only updates at this edge.
            if (bypass) begin
                act_cycle_d = wr_cycle;
                act_div_d   = wr_freq_div;
                act_rep_d   = wr_rep;
            end else begin
                act_cycle_d = bank_cycle[switch_seg];
                act_div_d   = bank_div[switch_seg];
                act_rep_d   = bank_rep[switch_seg];
            end
        end else if (!stop_q) begin
            if (tick) begin
                div_cnt_d = '0;
                if (at_end) begin
                    if (finish) begin
                        stop_d = 1'b1;        // idx held at cycle
                    end else begin
                        idx_d      = '0;
                        loop_cnt_d = loop_cnt_q + 1'b1;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            seg_q       <= '0;
            stop_q      <= 1'b0;
            div_cnt_q   <= '0;
            loop_cnt_q  <= '0;
            act_cycle_q <= '0;
            act_div_q   <= '0;
            act_rep_q   <= '1;
        end else begin
            idx_q       <= idx_d;
            seg_q       <= seg_d;
            stop_q      <= stop_d;
            div_cnt_q   <= div_cnt_d;
            loop_cnt_q  <= loop_cnt_d;
            act_cycle_q <= act_cycle_d;
            act_div_q   <= act_div_d;
            act_rep_q   <= act_rep_d;
        end
    end

    // ---------------------------------------------------------------------
    // Settings bank
    // ---------------------------------------------------------------------
    // NOTE: the bank must come out of reset with defined defaults, so it is
    // built from resettable flops rather than a RAM that cannot be cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SEGMENTS; i++) begin
                bank_cycle[i] <= '0;
                bank_div[i]   <= '0;
                bank_rep[i]   <= '1;
            end
        end else if (wr_ok) begin
            bank_cycle[wr_segment] <= wr_cycle;
            bank_div[wr_segment]   <= wr_freq_div;
            bank_rep[wr_segment]   <= wr_rep;
        end
    end

endmodule

// File: tb/tb_segment_sequencer.sv
// -----------------------------------------------------------------------------
// tb_segment_sequencer
//
// Drives segment_sequencer with directed scenarios followed by random traffic.
// The reference model tracks the number of clocks since the last segment
// switch and derives idx / stop / wrap arithmetically from the active settings.
// Expected outputs are queued by the driver and compared by a monitor process.
// -----------------------------------------------------------------------------
module tb_segment_sequencer;

    localparam int NS = 3;
    localparam int CW = 16;
    localparam int FW = 32;
    localparam int RW = 32;
    localparam longint INF = 64'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [1:0]    wr_segment;
    logic [CW-1:0] wr_cycle;
    logic [FW-1:0] wr_freq_div;
    logic [RW-1:0] wr_rep;
    logic          update;
    logic [1:0]    req_segment;
    logic [1:0]    req_mode;
    logic          sync;
    logic [CW-1:0] idx;
    logic [1:0]    segment;
    logic          stop;
    logic          pending;

    segment_sequencer #(
        .NUM_SEGMENTS  (NS),
        .CYCLE_WIDTH   (CW),
        .FREQ_DIV_WIDTH(FW),
        .REP_WIDTH     (RW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_segment (wr_segment),
        .wr_cycle   (wr_cycle),
        .wr_freq_div(wr_freq_div),
        .wr_rep     (wr_rep),
        .update     (update),
        .req_segment(req_segment),
        .req_mode   (req_mode),
        .sync       (sync),
        .idx        (idx),
        .segment    (segment),
        .stop       (stop),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks_total++;
        if (act == exp) checks_passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int     b_cycle [NS];
    int     b_div   [NS];
    longint b_rep   [NS];
    int     m_seg;
    longint m_clk;          // clocks since the last switch
    int     a_cycle;
    int     a_div;
    longint a_rep;
    bit     m_pend;
    int     m_pseg;
    int     m_pmode;

    function automatic longint eff_div();
        return (a_div == 0) ? 1 : longint'(a_div);
    endfunction

    function automatic longint period();
        return longint'(a_cycle + 1) * eff_div();
    endfunction

    // Finite segments play (rep+1) full periods, then hold.
    function automatic bit m_stopped();
        if (a_rep == INF) return 1'b0;
        return m_clk >= (a_rep + 1) * period();
    endfunction

    function automatic int m_idx();
        if (m_stopped()) return a_cycle;
        return int'((m_clk / eff_div()) % longint'(a_cycle + 1));
    endfunction

    function automatic bit m_wrap();
        return !m_stopped() && (((m_clk + 1) % period()) == 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            b_cycle[i] = 0;
            b_div[i]   = 0;
            b_rep[i]   = INF;
        end
        m_seg = 0; m_clk = 0; a_cycle = 0; a_div = 0; a_rep = INF;
        m_pend = 0; m_pseg = 0; m_pmode = 0;
    endtask

    task automatic model_step(input bit r, input bit we, input int ws, input int wc,
                              input int wd, input longint wrp, input bit up,
                              input int rs, input int rm, input bit sy);
        bit wr_ok, up_ok, stopped, wrapped, imm, trig;
        int mode, target;
        if (r) begin
            model_reset();
            return;
        end
        wr_ok   = we && ws < NS;
        up_ok   = up && rs < NS;
        mode    = (rm == 3) ? 0 : rm;
        stopped = m_stopped();
        wrapped = m_wrap();
        imm     = up_ok && (mode == 0 || (mode == 1 && stopped));
        trig    = m_pend && ((m_pmode == 1 && (wrapped || stopped)) ||
                             (m_pmode == 2 && sy));
        target  = imm ? rs : (trig ? m_pseg : -1);
        if (imm) m_pend = 0;
        else if (up_ok) begin
            m_pend = 1; m_pseg = rs; m_pmode = mode;
        end else if (trig) m_pend = 0;
        if (target >= 0) begin
            m_seg = target;
            m_clk = 0;
            if (wr_ok && ws == target) begin
                a_cycle = wc; a_div = wd; a_rep = wrp;
            end else begin
                a_cycle = b_cycle[target]; a_div = b_div[target]; a_rep = b_rep[target];
            end
        end else begin
            m_clk++;
        end
        if (wr_ok) begin
            b_cycle[ws] = wc; b_div[ws] = wd; b_rep[ws] = wrp;
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int idx;
        int seg;
        bit stop;
        bit pend;
    } exp_t;

    exp_t exp_q[$];

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_idx",     idx,     e.idx);
                check("sb_segment", segment, e.seg);
                check("sb_stop",    stop,    e.stop);
                check("sb_pending", pending, e.pend);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input bit r, input bit we, input int ws, input int wc,
                        input int wd, input longint wrp, input bit up,
                        input int rs, input int rm, input bit sy);
        exp_t e;
        @(negedge clk);
        rst         = r;
        wr_en       = we;
        wr_segment  = 2'(ws);
        wr_cycle    = 16'(wc);
        wr_freq_div = 32'(wd);
        wr_rep      = 32'(wrp);
        update      = up;
        req_segment = 2'(rs);
        req_mode    = 2'(rm);
        sync        = sy;
        model_step(r, we, ws, wc, wd, wrp, up, rs, rm, sy);
        e.idx  = m_idx();
        e.seg  = m_seg;
        e.stop = m_stopped();
        e.pend = m_pend;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq_a [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        int seq_b [6]  = '{0, 1, 0, 1, 1, 1};
        int stop_b [6] = '{0, 0, 0, 0, 1, 1};
        int rep_pick;

        rst = 1'b1; wr_en = 0; wr_segment = 0; wr_cycle = 0; wr_freq_div = 0;
        wr_rep = 0; update = 0; req_segment = 0; req_mode = 0; sync = 0;
        model_reset();

        // Reset and bank[0] defaults
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("reset_idx", idx, 0);
        check("reset_segment", segment, 0);
        check("reset_stop", stop, 0);
        check("reset_pending", pending, 0);
        idle(4);

        // bank[0] CYCLE=3 DIV=2 infinite
        step(0, 1, 0, 3, 2, INF, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            after_edge();
            check("div2_idx", idx, seq_a[i]);
            check("div2_stop", stop, 0);
            idle(1);
        end

        // bank[1] CYCLE=1 DIV=1 REP=1, immediate switch, runs out
        step(0, 1, 1, 1, 1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            after_edge();
            check("finite_idx", idx, seq_b[i]);
            check("finite_stop", stop, stop_b[i]);
            idle(1);
        end

        // seg0 CYCLE=3 DIV=1, AT_WRAP request at idx 1
        step(0, 1, 0, 3, 1, INF, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        after_edge(); check("wrap_start_idx", idx, 0);
        idle(1);
        after_edge(); check("wrap_pre_idx", idx, 1);
        step(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        after_edge(); check("wrap_idx2", idx, 2); check("wrap_pend2", pending, 1);
        idle(1);
        after_edge(); check("wrap_idx3", idx, 3); check("wrap_pend3", pending, 1);
        idle(1);
        after_edge(); check("wrap_seg", segment, 1); check("wrap_idx0", idx, 0);
        check("wrap_pend_clr", pending, 0);

        // AT_SYNC to seg0: same-cycle sync ignored, then sync 10 cycles later
        // together with a write of seg0 (bypass into the active copy)
        step(0, 0, 0, 0, 0, 0, 1, 0, 2, 1);
        for (int i = 0; i < 10; i++) begin
            after_edge();
            check("sync_pending", pending, 1);
            check("sync_old_seg", segment, 1);
            if (i < 9) idle(1);
        end
        step(0, 1, 0, 5, 1, INF, 0, 0, 0, 1);
        after_edge(); check("sync_seg", segment, 0); check("sync_pend_clr", pending, 0);
        check("sync_idx0", idx, 0);
        for (int i = 1; i <= 5; i++) begin
            idle(1);
            after_edge();
            check("bypass_idx", idx, i);
        end

        // Reset while PENDING at idx 2 of seg1
        step(0, 1, 1, 5, 1, INF, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        idle(1);
        after_edge(); check("rst_pre_idx", idx, 1);
        step(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        after_edge(); check("rst_pre_idx2", idx, 2); check("rst_pre_pend", pending, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("rst_async_seg", segment, 0);
        check("rst_async_idx", idx, 0);
        check("rst_async_pend", pending, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            after_edge();
            check("rst_bank_seg", segment, 1);
            check("rst_bank_idx", idx, 0);
            idle(1);
        end

        // Random traffic, including out-of-range segments and reserved mode
        for (int i = 0; i < 1500; i++) begin
            rep_pick = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 3));
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 4) == 0,
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 5)),
                 int'($urandom_range(0, 3)),
                 (rep_pick < 0) ? INF : longint'(rep_pick),
                 $urandom_range(0, 9) == 0,
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)),
                 $urandom_range(0, 9) == 0);
        end

        idle(2);
        @(posedge clk);
        #3;
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
